// File: rtl/sd_arb_pkg.sv
// Shared types for the SD sector-read arbiter: one-hot FSM states, owner codes,
// watchdog counter width and the tie-break helper.
package sd_arb_pkg;

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    ISSUE     = 5'b00010,
    WAIT_BUSY = 5'b00100,
    BUSY      = 5'b01000,
    DONE      = 5'b10000
  } arb_state_e;

  typedef enum logic {
    OWN_REQ0 = 1'b0,
    OWN_REQ1 = 1'b1
  } owner_e;

  // Wide enough for the default 2,000,000-cycle busy budget with margin.
  localparam int TMO_CNT_W = 32;

  function automatic owner_e pick_owner(input logic   r0,
                                        input logic   r1,
                                        input owner_e last,
                                        input logic   fix_prio);
    if (r0 && r1) begin
      if (fix_prio) return OWN_REQ0;
      return (last == OWN_REQ0) ? OWN_REQ1 : OWN_REQ0;
    end
    return r1 ? OWN_REQ1 : OWN_REQ0;
  endfunction

endpackage

// File: rtl/sd_arb_wdog.sv
// Watchdog counter for the SD read arbiter: counts while run_i, clears on clr_i,
// and flags expire_o once the count reaches limit_i. Used only with SD_RD_TIMEOUT_EN.
module sd_arb_wdog
  import sd_arb_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  input  logic                 run_i,
  input  logic [TMO_CNT_W-1:0] limit_i,
  output logic                 expire_o
);

  logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = run_i && (cnt_q >= limit_i);

  // Counter freezes once expired so it can never wrap back below the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && !expire_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sd_rd_arbiter.sv
// Shares one SD sector-read port between the image reader (req0) and the ISP LUT loader (req1).
// Optional macro SD_RD_TIMEOUT_EN adds start/busy watchdogs that abort a stuck sector via reqN_err.
module sd_rd_arbiter
  import sd_arb_pkg::*;
#(
  parameter int FIX_PRIO = 0,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 16
`ifdef SD_RD_TIMEOUT_EN
  ,
  parameter int START_TMO = 4096,
  parameter int BUSY_TMO  = 2000000
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              req0_en,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ack,
  output logic              req0_done,
  output logic              req0_err,
  output logic              req0_dvld,
  input  logic              req1_en,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ack,
  output logic              req1_done,
  output logic              req1_err,
  output logic              req1_dvld,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              sd_rd_en,
  output logic [ADDR_W-1:0] sd_rd_addr,
  input  logic              sd_rd_busy,
  input  logic              sd_rd_data_en,
  input  logic [DATA_W-1:0] sd_rd_data
);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_dly_q;
  logic              dvld0_q, dvld1_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              in_xfer;
  logic              abort;

  assign in_xfer = (state_q == WAIT_BUSY) || (state_q == BUSY);

`ifdef SD_RD_TIMEOUT_EN
  logic                 wd_clr;
  logic                 wd_expire;
  logic [TMO_CNT_W-1:0] wd_limit;
  logic                 err0_q, err1_q;

  // Restart at issue and again when busy rises, so each phase gets its own budget.
  assign wd_clr   = (state_q == ISSUE) || ((state_q == WAIT_BUSY) && sd_rd_busy);
  assign wd_limit = (state_q == WAIT_BUSY) ? TMO_CNT_W'(START_TMO) : TMO_CNT_W'(BUSY_TMO);

  sd_arb_wdog u_wdog (
    .clk_i    (sys_clk),
    .rst_n_i  (sys_rst_n),
    .clr_i    (wd_clr),
    .run_i    (in_xfer),
    .limit_i  (wd_limit),
    .expire_o (wd_expire)
  );

  assign abort = wd_expire;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      err0_q <= 1'b0;
      err1_q <= 1'b0;
    end else begin
      err0_q <= abort && (owner_q == OWN_REQ0);
      err1_q <= abort && (owner_q == OWN_REQ1);
    end
  end

  assign req0_err = err0_q;
  assign req1_err = err1_q;
`else
  assign abort    = 1'b0;
  assign req0_err = 1'b0;
  assign req1_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: begin
        if (!sd_rd_busy && (req0_en || req1_en)) begin
          owner_d = pick_owner(req0_en, req1_en, last_q, FIX_PRIO != 0);
          addr_d  = (owner_d == OWN_REQ1) ? req1_addr : req0_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_BUSY;
      WAIT_BUSY: begin
        if (abort) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else if (sd_rd_busy) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (abort) begin
          last_d  = owner_q;
          state_d = IDLE;
        end else if (busy_dly_q && !sd_rd_busy) begin
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset clears everything visible on the ports; a sector in flight is simply dropped.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_REQ0;
      last_q     <= OWN_REQ1;
      addr_q     <= '0;
      busy_dly_q <= 1'b0;
      dvld0_q    <= 1'b0;
      dvld1_q    <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      busy_dly_q <= sd_rd_busy;
      dvld0_q    <= sd_rd_data_en && in_xfer && (owner_q == OWN_REQ0);
      dvld1_q    <= sd_rd_data_en && in_xfer && (owner_q == OWN_REQ1);
      if (sd_rd_data_en) begin
        rd_data_q <= sd_rd_data;
      end
    end
  end

  assign sd_rd_en   = (state_q == ISSUE);
  assign sd_rd_addr = addr_q;
  assign req0_ack   = (state_q == ISSUE) && (owner_q == OWN_REQ0);
  assign req1_ack   = (state_q == ISSUE) && (owner_q == OWN_REQ1);
  assign req0_done  = (state_q == DONE) && (owner_q == OWN_REQ0);
  assign req1_done  = (state_q == DONE) && (owner_q == OWN_REQ1);
  assign req0_dvld  = dvld0_q;
  assign req1_dvld  = dvld1_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: tb/tb_sd_rd_arbiter.sv
// Self-checking bench for sd_rd_arbiter: a round-robin and a fixed-priority instance share stimulus.
// Timeout scenario runs only when SD_RD_TIMEOUT_EN is defined.
module tb_sd_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_en = 1'b0, req1_en = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic          busy = 1'b0, den = 1'b0;
  logic [DW-1:0] dat = '0;

  logic a_ack0, a_done0, a_err0, a_dv0, a_ack1, a_done1, a_err1, a_dv1, a_rden;
  logic b_ack0, b_done0, b_err0, b_dv0, b_ack1, b_done1, b_err1, b_dv1, b_rden;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] a_addr, b_addr;

  int n_chk = 0;
  int n_pass = 0;
  int cnt_a [9] = '{default: 0};
  int cnt_b [9] = '{default: 0};
  localparam int K_ACK0 = 0, K_ACK1 = 1, K_DONE0 = 2, K_DONE1 = 3, K_ERR0 = 4;
  localparam int K_ERR1 = 5, K_DV0 = 6, K_DV1 = 7, K_RDEN = 8;

  always #5 clk = ~clk;

  sd_rd_arbiter #(.FIX_PRIO(0), .ADDR_W(AW), .DATA_W(DW)
`ifdef SD_RD_TIMEOUT_EN
    , .START_TMO(16)
`endif
  ) dut_rr (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0_en(req0_en), .req0_addr(req0_addr), .req0_ack(a_ack0), .req0_done(a_done0),
    .req0_err(a_err0), .req0_dvld(a_dv0),
    .req1_en(req1_en), .req1_addr(req1_addr), .req1_ack(a_ack1), .req1_done(a_done1),
    .req1_err(a_err1), .req1_dvld(a_dv1),
    .rd_data_o(a_rdata), .sd_rd_en(a_rden), .sd_rd_addr(a_addr),
    .sd_rd_busy(busy), .sd_rd_data_en(den), .sd_rd_data(dat)
  );

  sd_rd_arbiter #(.FIX_PRIO(1), .ADDR_W(AW), .DATA_W(DW)
`ifdef SD_RD_TIMEOUT_EN
    , .START_TMO(16)
`endif
  ) dut_fp (
    .sys_clk(clk), .sys_rst_n(rst_n),
    .req0_en(req0_en), .req0_addr(req0_addr), .req0_ack(b_ack0), .req0_done(b_done0),
    .req0_err(b_err0), .req0_dvld(b_dv0),
    .req1_en(req1_en), .req1_addr(req1_addr), .req1_ack(b_ack1), .req1_done(b_done1),
    .req1_err(b_err1), .req1_dvld(b_dv1),
    .rd_data_o(b_rdata), .sd_rd_en(b_rden), .sd_rd_addr(b_addr),
    .sd_rd_busy(busy), .sd_rd_data_en(den), .sd_rd_data(dat)
  );

  logic [8:0] a_pl, b_pl;
  logic [9+DW+AW-1:0] a_all, b_all;
  assign a_pl  = {a_rden, a_dv1, a_dv0, a_err1, a_err0, a_done1, a_done0, a_ack1, a_ack0};
  assign b_pl  = {b_rden, b_dv1, b_dv0, b_err1, b_err0, b_done1, b_done0, b_ack1, b_ack0};
  assign a_all = {a_pl, a_rdata, a_addr};
  assign b_all = {b_pl, b_rdata, b_addr};

  // Pulse counters for both instances, sampled away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 9; k++) begin
      cnt_a[k] <= cnt_a[k] + int'(a_pl[k]);
      cnt_b[k] <= cnt_b[k] + int'(b_pl[k]);
    end
  end

  // Reference arbitration rule: returns 1 when req1 should own the next sector.
  function automatic bit exp_owner(bit r0, bit r1, bit last_was_1, bit fix);
    if (r0 && r1) return fix ? 1'b0 : !last_was_1;
    return r1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_issue(input int budget, output bit seen, output int n);
    seen = 1'b0;
    n = 0;
    while (n < budget) begin
      if (a_rden === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_chk++; if (a_all !== '0) $display("FAIL reset_rr: outputs %0h, expected 0", a_all); else n_pass++;
    n_chk++; if (b_all !== '0) $display("FAIL reset_fp: outputs %0h, expected 0", b_all); else n_pass++;
    rst_n = 1'b1;
    tick();
    tick();
    n_chk++; if (a_all !== '0) $display("FAIL idle_rr: outputs %0h, expected 0", a_all); else n_pass++;
  endtask

  task automatic test_single_req0();
    int s [9];
    s = cnt_a;
    req0_addr = 32'd24832;
    req0_en = 1'b1;
    tick();
    n_chk++; if ({a_rden, a_ack0, a_ack1} !== 3'b110)
      $display("FAIL single_issue: rden/ack0/ack1 %b, expected 110", {a_rden, a_ack0, a_ack1}); else n_pass++;
    n_chk++; if (a_addr !== 32'd24832) $display("FAIL single_addr: got %0d, expected 24832", a_addr); else n_pass++;
    req0_en = 1'b0;
    tick();
    n_chk++; if (a_rden !== 1'b0) $display("FAIL single_rden_pulse: got %b, expected 0", a_rden); else n_pass++;
    tick();
    busy = 1'b1;
    repeat (600) tick();
    busy = 1'b0;
    tick();
    n_chk++; if (a_done0 !== 1'b1) $display("FAIL single_done: got %b, expected 1", a_done0); else n_pass++;
    tick();
    tick();
    n_chk++; if (cnt_a[K_DONE0] - s[K_DONE0] !== 1)
      $display("FAIL single_done_count: got %0d, expected 1", cnt_a[K_DONE0] - s[K_DONE0]); else n_pass++;
    n_chk++; if (cnt_a[K_RDEN] - s[K_RDEN] !== 1)
      $display("FAIL single_rden_count: got %0d, expected 1", cnt_a[K_RDEN] - s[K_RDEN]); else n_pass++;
    n_chk++; if ((cnt_a[K_ACK1] + cnt_a[K_DONE1] + cnt_a[K_DV1] + cnt_a[K_ERR1])
                 - (s[K_ACK1] + s[K_DONE1] + s[K_DV1] + s[K_ERR1]) !== 0)
      $display("FAIL single_req1_quiet: req1 pulses seen, expected none"); else n_pass++;
  endtask

  task automatic test_arbitration();
    bit seen, eo_a, eo_b, last_a, last_b;
    int n, len;
    logic [3:0] ord_a, ord_b;
    logic [AW-1:0] ea, eb;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    last_a = 1'b1;
    last_b = 1'b1;
    ord_a = '0;
    ord_b = '0;
    req0_addr = $urandom;
    req1_addr = $urandom;
    req0_en = 1'b1;
    req1_en = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_issue(20, seen, n);
      n_chk++; if (!seen) begin
        $display("FAIL arb_issue: sector %0d got no sd_rd_en, expected one within 20 cycles", s);
        req0_en = 1'b0;
        req1_en = 1'b0;
        return;
      end else n_pass++;
      if (s > 0) begin
        n_chk++; if (n !== 2) $display("FAIL arb_gap: %0d cycles after done, expected 2", n); else n_pass++;
      end
      eo_a = exp_owner(1'b1, 1'b1, last_a, 1'b0);
      eo_b = exp_owner(1'b1, 1'b1, last_b, 1'b1);
      ea = eo_a ? req1_addr : req0_addr;
      eb = eo_b ? req1_addr : req0_addr;
      n_chk++; if ({a_ack1, a_ack0} !== {eo_a, !eo_a})
        $display("FAIL rr_ack: sector %0d got %b, expected %b", s, {a_ack1, a_ack0}, {eo_a, !eo_a}); else n_pass++;
      n_chk++; if (a_addr !== ea) $display("FAIL rr_addr: got %0h, expected %0h", a_addr, ea); else n_pass++;
      n_chk++; if ({b_rden, b_ack1, b_ack0} !== {1'b1, eo_b, !eo_b})
        $display("FAIL fp_ack: sector %0d got %b, expected %b", s, {b_rden, b_ack1, b_ack0}, {1'b1, eo_b, !eo_b}); else n_pass++;
      n_chk++; if (b_addr !== eb) $display("FAIL fp_addr: got %0h, expected %0h", b_addr, eb); else n_pass++;
      ord_a[s] = a_ack1;
      ord_b[s] = b_ack1;
      req0_addr = $urandom;
      req1_addr = $urandom;
      tick();
      tick();
      busy = 1'b1;
      len = $urandom_range(4, 30);
      repeat (len) tick();
      n_chk++; if ({a_addr, b_addr} !== {ea, eb})
        $display("FAIL arb_addr_hold: got %0h/%0h, expected %0h/%0h", a_addr, b_addr, ea, eb); else n_pass++;
      busy = 1'b0;
      tick();
      n_chk++; if ({a_done1, a_done0, b_done1, b_done0} !== {eo_a, !eo_a, eo_b, !eo_b})
        $display("FAIL arb_done: got %b, expected %b", {a_done1, a_done0, b_done1, b_done0},
                 {eo_a, !eo_a, eo_b, !eo_b}); else n_pass++;
      last_a = eo_a;
      last_b = eo_b;
    end
    req0_en = 1'b0;
    req1_en = 1'b0;
    n_chk++; if (ord_a !== 4'b1010) $display("FAIL rr_order: got %b, expected 1010 (lsb first)", ord_a); else n_pass++;
    n_chk++; if (ord_b !== 4'b0000) $display("FAIL fp_order: got %b, expected 0000", ord_b); else n_pass++;
    tick();
  endtask

  task automatic test_data_steering();
    int s [9];
    bit seen;
    int n, sent, guard;
    s = cnt_a;
    req1_addr = $urandom;
    req1_en = 1'b1;
    wait_issue(10, seen, n);
    n_chk++; if (a_ack1 !== 1'b1) $display("FAIL data_ack1: got %b, expected 1", a_ack1); else n_pass++;
    req1_en = 1'b0;
    tick();
    tick();
    busy = 1'b1;
    sent = 0;
    guard = 0;
    while (sent < 256 && guard < 4000) begin
      den = ($urandom_range(0, 3) != 0);
      dat = DW'($urandom);
      tick();
      guard++;
      if (den) begin
        sent++;
        n_chk++; if (a_rdata !== dat) $display("FAIL data_value: got %0h, expected %0h", a_rdata, dat); else n_pass++;
        n_chk++; if ({a_dv1, a_dv0} !== 2'b10) $display("FAIL data_dvld: got %b, expected 10", {a_dv1, a_dv0}); else n_pass++;
      end
    end
    den = 1'b0;
    busy = 1'b0;
    tick();
    n_chk++; if (a_done1 !== 1'b1) $display("FAIL data_done1: got %b, expected 1", a_done1); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      den = 1'b1;
      dat = DW'($urandom);
      tick();
      n_chk++; if (a_rdata !== dat) $display("FAIL stray_value: got %0h, expected %0h", a_rdata, dat); else n_pass++;
    end
    den = 1'b0;
    tick();
    tick();
    n_chk++; if (cnt_a[K_DV1] - s[K_DV1] !== 256)
      $display("FAIL data_dv1_count: got %0d, expected 256", cnt_a[K_DV1] - s[K_DV1]); else n_pass++;
    n_chk++; if (cnt_a[K_DV0] - s[K_DV0] !== 0)
      $display("FAIL data_dv0_count: got %0d, expected 0", cnt_a[K_DV0] - s[K_DV0]); else n_pass++;
  endtask

  task automatic test_busy_hold();
    int s [9];
    logic [AW-1:0] ea;
    rst_n = 1'b0;
    busy = 1'b1;
    ea = $urandom;
    req0_addr = ea;
    req0_en = 1'b1;
    tick();
    rst_n = 1'b1;
    s = cnt_a;
    repeat (1000) tick();
    n_chk++; if (cnt_a[K_RDEN] - s[K_RDEN] !== 0)
      $display("FAIL hold_no_issue: %0d sd_rd_en pulses, expected 0", cnt_a[K_RDEN] - s[K_RDEN]); else n_pass++;
    busy = 1'b0;
    tick();
    n_chk++; if ({a_rden, a_ack0, a_addr} !== {2'b11, ea})
      $display("FAIL hold_issue: rden/ack0 %b addr %0h, expected 11 addr %0h", {a_rden, a_ack0}, a_addr, ea); else n_pass++;
    req0_en = 1'b0;
    tick();
    tick();
    busy = 1'b1;
    repeat (8) tick();
    busy = 1'b0;
    tick();
    n_chk++; if (a_done0 !== 1'b1) $display("FAIL hold_done: got %b, expected 1", a_done0); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_sector();
    int s [9];
    bit seen;
    int n;
    s = cnt_a;
    req0_addr = $urandom;
    req0_en = 1'b1;
    wait_issue(10, seen, n);
    req0_en = 1'b0;
    tick();
    tick();
    busy = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    n_chk++; if (a_all !== '0) $display("FAIL midrst_rr: outputs %0h, expected 0", a_all); else n_pass++;
    n_chk++; if (b_all !== '0) $display("FAIL midrst_fp: outputs %0h, expected 0", b_all); else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      den = 1'b1;
      dat = DW'($urandom);
      tick();
      n_chk++; if ({a_dv1, a_dv0, b_dv1, b_dv0} !== 4'b0000)
        $display("FAIL midrst_dvld: got %b, expected 0000", {a_dv1, a_dv0, b_dv1, b_dv0}); else n_pass++;
    end
    den = 1'b0;
    busy = 1'b0;
    repeat (4) tick();
    n_chk++; if ((cnt_a[K_DONE0] + cnt_a[K_ERR0]) - (s[K_DONE0] + s[K_ERR0]) !== 0)
      $display("FAIL midrst_no_done: done/err pulses seen, expected none"); else n_pass++;
    n_chk++; if (cnt_a[K_RDEN] - s[K_RDEN] !== 1)
      $display("FAIL midrst_rden: got %0d issues, expected 1", cnt_a[K_RDEN] - s[K_RDEN]); else n_pass++;
  endtask

`ifdef SD_RD_TIMEOUT_EN
  task automatic test_timeout();
    int s [9];
    bit seen;
    int n, waited;
    s = cnt_a;
    req0_addr = $urandom;
    req0_en = 1'b1;
    wait_issue(10, seen, n);
    n_chk++; if (a_ack0 !== 1'b1) $display("FAIL tmo_ack0: got %b, expected 1", a_ack0); else n_pass++;
    req0_en = 1'b0;
    req1_addr = $urandom;
    req1_en = 1'b1;
    waited = 0;
    while (a_err0 !== 1'b1 && waited < 60) begin
      tick();
      waited++;
    end
    n_chk++; if (waited <= 16 || waited > 20)
      $display("FAIL tmo_err0_time: err after %0d cycles, expected 17..20", waited); else n_pass++;
    wait_issue(10, seen, n);
    n_chk++; if ({seen, a_ack1, a_addr} !== {2'b11, req1_addr})
      $display("FAIL tmo_req1_grant: seen/ack1 %b addr %0h, expected 11 addr %0h", {seen, a_ack1}, a_addr, req1_addr); else n_pass++;
    req1_en = 1'b0;
    tick();
    tick();
    busy = 1'b1;
    repeat (5) tick();
    busy = 1'b0;
    tick();
    n_chk++; if (a_done1 !== 1'b1) $display("FAIL tmo_done1: got %b, expected 1", a_done1); else n_pass++;
    tick();
    tick();
    n_chk++; if (cnt_a[K_ERR0] - s[K_ERR0] !== 1)
      $display("FAIL tmo_err0_count: got %0d, expected 1", cnt_a[K_ERR0] - s[K_ERR0]); else n_pass++;
    n_chk++; if (cnt_a[K_DONE0] - s[K_DONE0] !== 0)
      $display("FAIL tmo_no_done0: got %0d, expected 0", cnt_a[K_DONE0] - s[K_DONE0]); else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    int s [9];
    bit seen;
    int n;
    s = cnt_a;
    req0_addr = $urandom;
    req0_en = 1'b1;
    wait_issue(10, seen, n);
    req0_en = 1'b0;
    repeat (300) tick();
    n_chk++; if ((cnt_a[K_ERR0] + cnt_a[K_DONE0]) - (s[K_ERR0] + s[K_DONE0]) !== 0)
      $display("FAIL notmo_quiet: err/done pulses seen, expected none"); else n_pass++;
    n_chk++; if (cnt_a[K_RDEN] - s[K_RDEN] !== 1)
      $display("FAIL notmo_rden: got %0d issues, expected 1", cnt_a[K_RDEN] - s[K_RDEN]); else n_pass++;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_req0();
    test_arbitration();
    test_data_steering();
    test_busy_hold();
    test_reset_mid_sector();
`ifdef SD_RD_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
